wb_write_queue: RTL and testbench

Write-side companion to the processor register file. Buffers writeback results (destination register plus 32-bit data) from the ALU/load path in a small FIFO. Drains them one per cycle onto the register file's single write port, and stalls while the port is blocked. Provides two forwarding lookup ports, matched to the register file's two read ports, so pending writes are visible to readers before they retire.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/wb_fwd_match.sv | 42 ++++
 rtl/wb_write_queue.sv | 131 +++++++++++++
 tb/tb_wb_write_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared processor definitions: register file geometry and the writeback entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_AW = 5;   // 32 architectural registers
  localparam int REG_DW = 32;  // datapath width

  // Register 0 always reads as zero, so writes to it are dropped.
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the pending writeback entries for one read port.
// Latency: combinational.
// Backpressure: none; pure lookup.
//
// Ports:
//   vld      - valid mask, bit i set when the i-th oldest entry is pending
//   ent_reg  - destination registers, index 0 = oldest
//   ent_data - result data, index 0 = oldest
//   lk_reg   - register being read
//   hit      - some pending entry targets lk_reg
//   data     - data of the youngest such entry, zero when no hit
module wb_fwd_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic [DEPTH-1:0]         vld,
  input  logic [DEPTH-1:0][AW-1:0] ent_reg,
  input  logic [DEPTH-1:0][DW-1:0] ent_data,
  input  logic [AW-1:0]            lk_reg,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  // Entries are presented oldest first, so scanning upward and letting the
  // last match win yields the youngest pending value.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (lk_reg != AW'(REG_ZERO)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && (ent_reg[i] == lk_reg)) begin
          hit  = 1'b1;
          data = ent_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue in front of the register file write port, with two forwarding lookups.
// Latency: a push into an empty queue is written to the register file the next cycle.
// Backpressure: wr_block holds the head; in_ready drops when DEPTH entries are held.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   in_valid/in_ready            - writeback handshake, in_reg/in_data payload
//   wr_block                     - register file write port busy this cycle
//   wr_en/wr_reg/wr_data         - register file write strobe and head entry
//   lk_reg1/lk_hit1/lk_data1     - forwarding lookup for read port 1
//   lk_reg2/lk_hit2/lk_data2     - forwarding lookup for read port 2
//   count                        - number of pending entries
module wb_write_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_reg,
  input  logic [DW-1:0]            in_data,
  input  logic                     wr_block,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_reg,
  output logic [DW-1:0]            wr_data,
  input  logic [AW-1:0]            lk_reg1,
  output logic                     lk_hit1,
  output logic [DW-1:0]            lk_data1,
  input  logic [AW-1:0]            lk_reg2,
  output logic                     lk_hit2,
  output logic [DW-1:0]            lk_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_reg  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic push;
  logic enq;
  logic pop;

  // in_ready depends only on registered count, so a full queue refuses input
  // even in a cycle where it drains. Both handshakes are gated during reset so
  // nothing is accepted or written while the queue is being flushed.
  assign in_ready = !rst && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign enq      = push && (in_reg != AW'(REG_ZERO));

  assign wr_en    = !rst && (count != '0) && !wr_block;
  assign pop      = wr_en;
  assign wr_reg   = mem_reg[rd_ptr];
  assign wr_data  = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_reg[wr_ptr]  <= in_reg;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Age-ordered view of the buffer: slot i is the i-th oldest entry. Only the
  // first count slots are valid, so the entry pushed this cycle stays hidden
  // and the entry being popped this cycle is still visible.
  logic [DEPTH-1:0]         ord_vld;
  logic [DEPTH-1:0][AW-1:0] ord_reg;
  logic [DEPTH-1:0][DW-1:0] ord_data;

  always_comb begin
    ord_vld  = '0;
    ord_reg  = '0;
    ord_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ord_vld[i]  = CW'(i) < count;
      ord_reg[i]  = mem_reg[rd_ptr + PW'(i)];
      ord_data[i] = mem_data[rd_ptr + PW'(i)];
    end
  end

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd1 (
    .vld      (ord_vld),
    .ent_reg  (ord_reg),
    .ent_data (ord_data),
    .lk_reg   (lk_reg1),
    .hit      (lk_hit1),
    .data     (lk_data1)
  );

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd2 (
    .vld      (ord_vld),
    .ent_reg  (ord_reg),
    .ent_data (ord_data),
    .lk_reg   (lk_reg2),
    .hit      (lk_hit2),
    .data     (lk_data2)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized and directed bench for wb_write_queue against a queue-based model.
// Latency: model entries become visible one cycle after their handshake.
// Backpressure: wr_block and queue fullness are driven and predicted by the model.
module tb_wb_write_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_data = '0;
  logic        wr_block = 1'b0;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  lk_reg1 = '0;
  logic        lk_hit1;
  logic [31:0] lk_data1;
  logic [4:0]  lk_reg2 = '0;
  logic        lk_hit2;
  logic [31:0] lk_data2;
  logic [2:0]  count;

  wb_write_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_reg   (in_reg),
    .in_data  (in_data),
    .wr_block (wr_block),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .lk_reg1  (lk_reg1),
    .lk_hit1  (lk_hit1),
    .lk_data1 (lk_data1),
    .lk_reg2  (lk_reg2),
    .lk_hit2  (lk_hit2),
    .lk_data2 (lk_data2),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Pending register-file writes, oldest at index 0.
  wb_entry_t exp_q[$];
  logic      exp_ready = 1'b0;
  logic      armed = 1'b0;
  int        n_cmp = 0;
  int        n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_lk(input logic [4:0] r, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (r != 5'd0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (!h && exp_q[i].rd == r) begin
          h = 1'b1;
          d = exp_q[i].data;
        end
      end
    end
  endfunction

  // Monitor: compares every visible output against the model mid-cycle and
  // retires the head whenever the DUT presents a write.
  always @(negedge clk) begin
    int          n;
    logic        e_wr, e_rdy, h;
    logic [31:0] d;
    if (armed) begin
      n     = exp_q.size();
      e_wr  = !rst && (n != 0) && !wr_block;
      e_rdy = !rst && (n < DEPTH);
      chk("count",    {29'd0, count},    n);
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
      chk("wr_en",    {31'd0, wr_en},    {31'd0, e_wr});
      if (n != 0) begin
        chk("wr_reg",  {27'd0, wr_reg}, {27'd0, exp_q[0].rd});
        chk("wr_data", wr_data,         exp_q[0].data);
      end
      model_lk(lk_reg1, h, d);
      chk("lk_hit1",  {31'd0, lk_hit1}, {31'd0, h});
      chk("lk_data1", lk_data1, d);
      model_lk(lk_reg2, h, d);
      chk("lk_hit2",  {31'd0, lk_hit2}, {31'd0, h});
      chk("lk_data2", lk_data2, d);
      exp_ready = e_rdy;
      if (wr_en && n != 0) void'(exp_q.pop_front());
    end
  end

  // One clock of stimulus; the expected write is queued once the handshake
  // outcome for this cycle is known from the model.
  task automatic cyc(input logic r_st, input logic v, input logic [4:0] rg,
                     input logic [31:0] dt, input logic blk,
                     input logic [4:0] l1, input logic [4:0] l2);
    wb_entry_t e;
    @(posedge clk);
    #1;
    armed    = 1'b1;
    rst      = r_st;
    in_valid = v;
    in_reg   = rg;
    in_data  = dt;
    wr_block = blk;
    lk_reg1  = l1;
    lk_reg2  = l2;
    @(negedge clk);
    #1;
    if (v && exp_ready && rg != 5'd0) begin
      e.rd   = rg;
      e.data = dt;
      exp_q.push_back(e);
    end
    if (r_st) exp_q.delete();
  endtask

  initial begin
    // reset then idle
    cyc(1, 0, 0, 0, 0, 5, 0);
    cyc(1, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 5, 0);

    // single write
    cyc(0, 1, 3, 32'hDEADBEEF, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 3, 0);

    // fill while blocked, fifth push refused, then in-order drain
    for (int k = 1; k <= 5; k++)
      cyc(0, 1, 5'(k), 32'(k * 17), 1, 5'(k), 2);
    cyc(0, 0, 0, 0, 1, 4, 1);
    for (int k = 0; k < 6; k++)
      cyc(0, 0, 0, 0, 0, 1, 4);

    // youngest match forwarding
    cyc(0, 1, 7, 32'hA, 1, 7, 8);
    cyc(0, 1, 7, 32'hB, 1, 7, 8);
    cyc(0, 0, 0, 0, 1, 7, 8);
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0, 0, 0, 7, 8);

    // register zero is accepted but dropped
    cyc(0, 1, 0, 32'hFFFF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // reset mid-operation, then back-to-back stream across the wrap
    cyc(0, 1, 9,  32'h99, 1, 9, 10);
    cyc(0, 1, 10, 32'hAA, 1, 9, 10);
    cyc(0, 1, 11, 32'hBB, 1, 11, 10);
    cyc(1, 0, 0, 0, 0, 9, 10);
    cyc(0, 0, 0, 0, 0, 9, 11);
    cyc(0, 0, 0, 0, 0, 9, 11);
    for (int k = 0; k < 10; k++)
      cyc(0, 1, 5'(k + 1), $urandom, 0, 5'(k + 1), 5'(k));
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0, 0, 0, 1, 2);

    // random traffic
    for (int k = 0; k < 500; k++)
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 9) < 7,
          5'($urandom_range(0, 7)),
          $urandom,
          $urandom_range(0, 9) < 3,
          5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)));
    for (int k = 0; k < 6; k++)
      cyc(0, 0, 0, 0, 0, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
